// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle add/sub(/logic), iterative shift-add multiply and restoring divide.
// Define ALU_SEQ_LOGIC_OPS_EN to enable the and/or/xor opcodes (4, 5, 6).
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic [3:0]           op,
    input  logic                 invalid_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 zero,
    output logic                 error
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
`ifdef ALU_SEQ_LOGIC_OPS_EN
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic              is_div;
    logic [RW-1:0]     acc;      // mul: partial product; div: remainder in low bits
    logic [RW-1:0]     mcand;    // mul: shifted multiplicand; div: divisor in low bits
    logic [WIDTH-1:0]  mplier;   // mul: multiplier bits; div: dividend shifting into quotient

    logic              legal, acc_err, go_calc;
    logic [RW-1:0]     fast_res;

    always_comb begin
        legal    = 1'b0;
        fast_res = '0;
        case (op)
            OP_ADD: begin
                legal    = 1'b1;
                fast_res = {{WIDTH{1'b0}}, in1} + {{WIDTH{1'b0}}, in2};
            end
            OP_SUB: begin
                legal    = 1'b1;
                fast_res = {{WIDTH{1'b0}}, in1} - {{WIDTH{1'b0}}, in2};
            end
            OP_MUL, OP_DIV: legal = 1'b1;
`ifdef ALU_SEQ_LOGIC_OPS_EN
            OP_AND: begin legal = 1'b1; fast_res = {{WIDTH{1'b0}}, in1 & in2}; end
            OP_OR:  begin legal = 1'b1; fast_res = {{WIDTH{1'b0}}, in1 | in2}; end
            OP_XOR: begin legal = 1'b1; fast_res = {{WIDTH{1'b0}}, in1 ^ in2}; end
`endif
            default: legal = 1'b0;
        endcase
    end

    assign acc_err = invalid_data || !legal || ((op == OP_DIV) && (in2 == '0));
    assign go_calc = !acc_err && ((op == OP_MUL) || (op == OP_DIV));

    // One iteration step; the remainder never exceeds the divisor, so W+1 bits hold the shifted value.
    logic [WIDTH:0]    rem_shift;
    logic [WIDTH+1:0]  diff;
    logic [RW-1:0]     acc_step, mcand_step, calc_res;
    logic [WIDTH-1:0]  mplier_step;

    always_comb begin
        rem_shift   = {acc[WIDTH-1:0], mplier[WIDTH-1]};
        diff        = {1'b0, rem_shift} - {2'b00, mcand[WIDTH-1:0]};
        acc_step    = acc;
        mcand_step  = mcand;
        mplier_step = mplier;
        if (is_div) begin
            if (diff[WIDTH+1]) begin
                acc_step    = {{(WIDTH-1){1'b0}}, rem_shift};
                mplier_step = {mplier[WIDTH-2:0], 1'b0};
            end else begin
                acc_step    = {{(WIDTH-1){1'b0}}, diff[WIDTH:0]};
                mplier_step = {mplier[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_step    = mplier[0] ? acc + mcand : acc;
            mcand_step  = mcand << 1;
            mplier_step = mplier >> 1;
        end
        calc_res = is_div ? {acc_step[WIDTH-1:0], mplier_step} : acc_step;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = go_calc ? CALC : DONE;
            end
            CALC: if (cnt == CW'(1)) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            is_div <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            out    <= '0;
            zero   <= 1'b0;
            error  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (acc_err) begin
                        out   <= '1;
                        zero  <= 1'b0;
                        error <= 1'b1;
                    end else if (go_calc) begin
                        cnt    <= CW'(WIDTH);
                        is_div <= (op == OP_DIV);
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, (op == OP_DIV) ? in2 : in1};
                        mplier <= (op == OP_DIV) ? in1 : in2;
                    end else begin
                        out   <= fast_res;
                        zero  <= (fast_res == '0);
                        error <= 1'b0;
                    end
                end
                CALC: begin
                    acc    <= acc_step;
                    mcand  <= mcand_step;
                    mplier <= mplier_step;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        out   <= calc_res;
                        zero  <= (calc_res == '0);
                        error <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH = 8).
module tb_alu_seq;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in1 = '0;
    logic [W-1:0]   in2 = '0;
    logic [3:0]     op = '0;
    logic           invalid_data = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] out;
    logic           zero;
    logic           error;

    int n_total = 0;
    int n_bad   = 0;
    int overlap = 0;

`ifdef ALU_SEQ_LOGIC_OPS_EN
    localparam logic [15:0] OR_EXP = 16'h00FF;
    localparam logic        OR_ERR = 1'b0;
`else
    localparam logic [15:0] OR_EXP = 16'hFFFF;
    localparam logic        OR_ERR = 1'b1;
`endif

    always #5 clk = ~clk;

    always @(negedge clk) if (in_ready && out_valid) overlap++;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .op(op), .invalid_data(invalid_data),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .zero(zero), .error(error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one operand set at a falling edge; returns in cycle 1 (after the acceptance edge).
    task automatic start_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic inv);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        op = o; in1 = a; in2 = b; invalid_data = inv; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; invalid_data = 1'b0;
    endtask

    task automatic wait_result(output int lat, output int ready_seen);
        lat = 1;
        ready_seen = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ready_seen++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("in_ready_after_hs", in_ready, 1);
        check("out_valid_after_hs", out_valid, 0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic inv, input logic [15:0] exp_out,
                          input logic exp_zero, input logic exp_err, input int exp_lat);
        int lat, rs;
        start_op(o, a, b, inv);
        wait_result(lat, rs);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_ready_low"}, rs, 0);
        check({tag, "_out"}, out, exp_out);
        check({tag, "_zero"}, zero, exp_zero);
        check({tag, "_err"}, error, exp_err);
        finish_op();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, rs;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_zero", zero, 0);
        check("rst_err", error, 0);
        #11 rst_n = 1'b1;

        run_op("add", 4'd0, 8'd200, 8'd100, 1'b0, 16'h012C, 1'b0, 1'b0, 1);
        run_op("sub_neg", 4'd1, 8'd5, 8'd7, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1);
        run_op("sub_zero", 4'd1, 8'd9, 8'd9, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
        run_op("mul", 4'd2, 8'd255, 8'd255, 1'b0, 16'hFE01, 1'b0, 1'b0, 9);
        run_op("mul_small", 4'd2, 8'd12, 8'd10, 1'b0, 16'h0078, 1'b0, 1'b0, 9);
        run_op("div", 4'd3, 8'd200, 8'd7, 1'b0, 16'h041C, 1'b0, 1'b0, 9);
        run_op("div0", 4'd3, 8'd13, 8'd0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1);
        run_op("poison", 4'd0, 8'd1, 8'd1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1);
        run_op("illegal", 4'd9, 8'd1, 8'd1, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1);

        // Backpressure, then a back-to-back or.
        start_op(4'd0, 8'd3, 8'd4, 1'b0);
        wait_result(lat, rs);
        check("bp_lat", lat, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out", out, 16'h0007);
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        finish_op();
        run_op("or", 4'd5, 8'h0F, 8'hF0, 1'b0, OR_EXP, 1'b0, OR_ERR, 1);

        // Reset in cycle 4 of a divide.
        start_op(4'd3, 8'd200, 8'd7, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out", out, 0);
        check("mid_rst_zero", zero, 0);
        check("mid_rst_err", error, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_op("div_after_rst", 4'd3, 8'd9, 8'd2, 1'b0, 16'h0104, 1'b0, 1'b0, 9);

        check("ready_valid_overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle, parametrised ALU with valid/ready handshakes on both the operand side and the result side. It extends the datapath's combinational ALU function set with an iterative shift-add multiplier and a restoring divider, registered result flags, and optional bitwise ops. It sits between the operand-fetch stage and the writeback register. Only one operation is in flight at any time.

## Interface
- WIDTH, 8, operand width in bits; must be at least 2. The result is 2*WIDTH bits wide.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept an operand set; high only in IDLE.
- in1, in2  input  WIDTH  unsigned operands.
- op  input  4  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor; all others illegal.
- invalid_data  input  1  upstream marks the operands as poisoned.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  downstream accepts the result.
- out  output  2*WIDTH  registered result.
- zero  output  1  registered flag: out == 0 and error == 0.
- error  output  1  registered flag: the operation failed.

## Operation
- FSM states are IDLE, CALC and DONE. The state encoding is internal.
- IDLE: in_ready = 1.
  - Acceptance is in_valid && in_ready at a rising edge. At acceptance, in1, in2, op and invalid_data are latched.
  - add, sub, and logic ops: the result is computed and registered at the acceptance edge, and the FSM moves to DONE.
  - mul or div with no error condition: the FSM moves to CALC with the iteration counter set to WIDTH.
  - Error condition: invalid_data = 1 with any opcode, div with in2 == 0, or an illegal op. The FSM moves straight to DONE with out = all ones and error = 1.
- CALC: one shift-add or restoring-subtract step per cycle, and the counter decrements each step. When the counter reaches 0, out, zero and error are registered and the FSM moves to DONE. Inputs are ignored while in CALC.
- DONE: out_valid = 1, and out, zero and error hold stable. When out_ready = 1 at an edge, the FSM returns to IDLE.
- Arithmetic rules. Operands are zero-extended to 2*WIDTH bits, and the result is taken mod 2^(2*WIDTH).
  - add: out = in1 + in2. The carry appears at bit WIDTH.
  - sub: out = in1 - in2. A negative result wraps, e.g. 5-7 gives all-ones minus 1.
  - mul: out = full unsigned product.
  - div: out[WIDTH-1:0] = quotient, out[2*WIDTH-1:WIDTH] = remainder.
  - and/or/xor: the bitwise result goes in the low half; the high half is 0.
- error is 0 for every successful operation. zero is never 1 while error = 1.

## Timing
- Reset values: the FSM is in IDLE, so in_ready = 1. out_valid = 0, out = 0, zero = 0, error = 0, and the counter = 0.
- Cycle 0 is the acceptance edge. Latency counts edges from acceptance to the first cycle with out_valid high.
  - add, sub, logic ops and error cases: out_valid is high in cycle 1 (latency 1).
  - mul and div: out_valid is high in cycle WIDTH+1 (latency WIDTH+1).
- A result handshake at edge N returns the FSM to IDLE, so in_ready is high in cycle N+1. The earliest next acceptance is edge N+1. Maximum throughput is therefore one operation per 2 cycles for single-cycle ops.
- in_ready and out_valid are never both high in the same cycle.
- Backpressure: DONE is held indefinitely while out_ready = 0, with outputs unchanged.
- out_ready is ignored outside DONE.
- rst_n low at any time, including mid-CALC or mid-DONE, immediately aborts the operation. All outputs return to their reset values asynchronously, and the pending result is lost.

## Configuration
- ALU_SEQ_LOGIC_OPS_EN
  - Defined: opcodes 4, 5 and 6 (and, or, xor) are legal, with single-cycle latency.
  - Undefined: opcodes 4, 5 and 6 are illegal. They follow the error path (out = all ones, error = 1, latency 1), and no logic-op hardware is synthesised.

## Test plan
All scenarios use WIDTH = 8.
- add 200+100: out = 0x012C, zero = 0, error = 0. out_valid is high in cycle 1.
- sub 5-7 → out = 0xFFFE, error = 0. Then sub 9-9 → out = 0x0000, zero = 1.
- mul 255*255: out = 0xFE01, out_valid is high in cycle 9, and in_ready stays low in cycles 1 to 9.
- div 200/7 → out = 0x041C (quotient 28, remainder 4) in cycle 9. Then div 13/0 → out = 0xFFFF, error = 1, zero = 0 in cycle 1. Then add 1+1 with invalid_data = 1 → out = 0xFFFF, error = 1.
- Backpressure and throughput: add 3+4 with out_ready = 0 for 3 cycles. out = 0x0007 stays stable and in_ready stays 0. Then raise out_ready. in_ready is high the next cycle, and a back-to-back or 0x0F|0xF0 yields 0x00FF. Without ALU_SEQ_LOGIC_OPS_EN, the same or op yields 0xFFFF with error = 1.
- Reset mid-division: assert rst_n = 0 in cycle 4 of a div. All outputs drop immediately to their reset values. After release, in_ready = 1 and a fresh div 9/2 yields 0x0104.
